// File: rtl/mux_arb_pkg.sv
// Shared encodings for the two-requester arbiter: FSM states and last-grant codes.
package mux_arb_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    GRANT_A = 2'b01,
    GRANT_B = 2'b10
  } arb_state_e;

  typedef enum logic {
    LAST_A = 1'b0,
    LAST_B = 1'b1
  } last_gnt_e;

endpackage

// File: rtl/mux2_1.sv
// Single-bit 2:1 multiplexer; y follows b when sel is high, else a.
module mux2_1 (
  input  logic a,
  input  logic b,
  input  logic sel,
  output logic y
);

  assign y = sel ? b : a;

endmodule

// File: rtl/mux_arbiter2.sv
// Two-requester round-robin arbiter with bounded hold under contention,
// steering a shared Width-bit path through a bank of 1-bit muxes.
module mux_arbiter2
  import mux_arb_pkg::*;
#(
  parameter int unsigned Width   = 8,
  parameter int unsigned MaxHold = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ReqA,
  input  logic             ReqB,
  input  logic [Width-1:0] InA,
  input  logic [Width-1:0] InB,
  output logic             GntA,
  output logic             GntB,
  output logic             S,
  output logic [Width-1:0] Out,
  output logic             Busy
);

  localparam int unsigned HW = (MaxHold > 0) ? $clog2(MaxHold + 1) : 1;
  localparam logic [HW-1:0] HoldMax  = HW'(MaxHold);
  localparam logic [HW-1:0] HoldLast = (MaxHold > 0) ? HW'(MaxHold - 1) : '0;

  arb_state_e     state_q, state_d;
  last_gnt_e      last_q, last_d;
  logic [HW-1:0]  hold_q, hold_d;
  logic           s_q, s_d;
  logic           gnt_a_q, gnt_a_d;
  logic           gnt_b_q, gnt_b_d;
  logic           busy_q, busy_d;
  logic           hold_expired;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      last_q  <= LAST_B;
      hold_q  <= '0;
      s_q     <= 1'b0;
      gnt_a_q <= 1'b0;
      gnt_b_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      hold_q  <= hold_d;
      s_q     <= s_d;
      gnt_a_q <= gnt_a_d;
      gnt_b_q <= gnt_b_d;
      busy_q  <= busy_d;
    end
  end

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    hold_d  = hold_q;
    s_d     = s_q;
    // >= rather than == so a counter already saturated by an uncontended
    // hold still yields as soon as the other side starts requesting.
    hold_expired = (MaxHold != 0) && (hold_q >= HoldLast);

    case (state_q)
      IDLE: begin
        if (ReqA && ReqB) state_d = (last_q == LAST_A) ? GRANT_B : GRANT_A;
        else if (ReqA)    state_d = GRANT_A;
        else if (ReqB)    state_d = GRANT_B;
      end
      GRANT_A: begin
        if (!ReqA)                     state_d = ReqB ? GRANT_B : IDLE;
        else if (ReqB && hold_expired) state_d = GRANT_B;
      end
      GRANT_B: begin
        if (!ReqB)                     state_d = ReqA ? GRANT_A : IDLE;
        else if (ReqA && hold_expired) state_d = GRANT_A;
      end
      default: state_d = IDLE;
    endcase

    if (state_d == IDLE || state_d != state_q) hold_d = '0;
    else if (hold_q != HoldMax)                hold_d = hold_q + HW'(1);

    if (state_d == GRANT_A) begin
      s_d = 1'b0;
      if (state_q != GRANT_A) last_d = LAST_A;
    end else if (state_d == GRANT_B) begin
      s_d = 1'b1;
      if (state_q != GRANT_B) last_d = LAST_B;
    end

    gnt_a_d = (state_d == GRANT_A);
    gnt_b_d = (state_d == GRANT_B);
    busy_d  = (state_d != IDLE);
  end

  assign GntA = gnt_a_q;
  assign GntB = gnt_b_q;
  assign S    = s_q;
  assign Busy = busy_q;

  for (genvar i = 0; i < Width; i++) begin : g_mux
    mux2_1 u_mux (
      .a   (InA[i]),
      .b   (InB[i]),
      .sel (s_q),
      .y   (Out[i])
    );
  end

endmodule

// File: doc/mux_arbiter2.md
MUX_ARBITER2 -- requirements
Module: mux_arbiter2

Interface
REQ-001 Parameter: Width, 8, data bits per requester path.
REQ-002 Parameter: MaxHold, 4, max consecutive grant cycles under contention; 0 = unlimited.
REQ-003 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-004 Port: rst_n  input  1  asynchronous, active-low reset.
REQ-005 Port: ReqA  input  1  requester A wants the shared path.
REQ-006 Port: ReqB  input  1  requester B wants the shared path.
REQ-007 Port: InA  input  Width  requester A data.
REQ-008 Port: InB  input  Width  requester B data.
REQ-009 Port: GntA  output  1  registered grant to A.
REQ-010 Port: GntB  output  1  registered grant to B.
REQ-011 Port: S  output  1  registered mux select; 0 = A, 1 = B.
REQ-012 Port: Out  output  Width  shared path, equal to InB when S=1, else InA (combinational from S).
REQ-013 Port: Busy  output  1  high when GntA or GntB high.

Function
REQ-014 States SHALL be IDLE, GRANT_A, GRANT_B; GntA=1 only in GRANT_A, GntB=1 only in GRANT_B; GntA&GntB never 1.
REQ-015 Grant latency SHALL be one cycle: Req sampled high at edge N -> Gnt high after edge N.
REQ-016 IDLE: only ReqA -> GRANT_A; only ReqB -> GRANT_B; both -> requester not in LastGnt register; neither -> stay IDLE.
REQ-017 LastGnt SHALL update to A or B on every entry to GRANT_A or GRANT_B.
REQ-018 GRANT_X with ReqX low SHALL release: other Req high -> GRANT_other directly (no IDLE bubble); else IDLE.
REQ-019 HoldCnt (clog2(MaxHold+1) bits) SHALL clear on entry to a grant state and increment each held cycle, saturating at MaxHold.
REQ-020 GRANT_X with ReqX high, other Req high, HoldCnt = MaxHold-1, MaxHold != 0 SHALL force switch to GRANT_other.
REQ-021 GRANT_X with ReqX high and other Req low SHALL hold indefinitely regardless of HoldCnt.
REQ-022 S SHALL be 0 in GRANT_A, 1 in GRANT_B, and retain its last value in IDLE.
REQ-023 ReqA and ReqB rising together in the same cycle as a release SHALL resolve per REQ-018 before REQ-016.
REQ-024 Busy SHALL equal GntA|GntB, registered alongside grants.

Reset
REQ-025 rst_n low SHALL asynchronously force IDLE, GntA=0, GntB=0, S=0, Busy=0, HoldCnt=0, LastGnt=B (A wins first tie).
REQ-026 Reset asserted mid-grant SHALL drop the grant immediately without waiting for a clock edge.
REQ-027 Deassertion SHALL take effect at the first rising clk edge with rst_n high; Req inputs are sampled from that edge.

Structure
REQ-028 State encodings (IDLE=2'b00, GRANT_A=2'b01, GRANT_B=2'b10) and the A/B LastGnt codes SHALL live in shared package mux_arb_pkg.
REQ-029 Out SHALL be built from Width instances of the existing 1-bit sub-module mux2_1 in a generate loop, all driven by S.
REQ-030 Arbitration FSM, HoldCnt and LastGnt SHALL be in mux_arbiter2 itself; no further sub-modules.

Verification
REQ-031 Reset: rst_n=0 with ReqA=ReqB=1 -> GntA=GntB=0, S=0, Busy=0 asynchronously; released -> GntA=1 one cycle later.
REQ-032 Single requester: ReqB=1 for 6 cycles, ReqA=0, InB=8'hA5 -> GntB=1 for 6 cycles, S=1, Out=8'hA5, no forced release.
REQ-033 Contention fairness: ReqA=ReqB=1 held 16 cycles, MaxHold=4 -> grants alternate A x4, B x4, A x4, B x4, no IDLE cycles.
REQ-034 Early release: GRANT_A, ReqA drops at cycle 2 while ReqB=1 -> GntB=1 next cycle, S=1, GntA=0 same cycle.
REQ-035 Tie after idle: last grant B, both idle, then ReqA=ReqB=1 same edge -> GRANT_A; repeat after A released -> GRANT_B.
REQ-036 Mid-grant reset: GntB=1, S=1, pulse rst_n low between edges -> GntB=0 and S=0 before next edge; exhaustive InA/InB/S check of Out per bit.
